jtcop_bac06_draw: RTL and testbench

Per-line tile renderer for one BAC06 playfield layer, directly downstream of the BAC06 tilemap RAM and scroll registers. On each line-start pulse it walks the tilemap row selected by `vrender` plus vertical scroll and fetches 4bpp tile rows from the graphics ROM. It writes 256 pixels into one half of an internal double line buffer, while the other half is streamed out at `pxl_cen` for the line being displayed.

---
 rtl/jtcop_pkg.sv | 25 ++
 rtl/jtcop_bac06_lbuf.sv | 53 +++++
 rtl/jtcop_bac06_draw.sv | 238 +++++++++++++++++++++++
 tb/tb_jtcop_bac06_draw.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtcop_pkg.sv
// Shared definitions for the BAC06 playfield renderer.
// Holds the render FSM state encoding, tilemap word field positions and
// the tilemap geometry (64 columns x 32 rows of 16x16 tiles).
package jtcop_pkg;

    // Tilemap geometry in tiles
    localparam int unsigned MAP_COLS = 64;
    localparam int unsigned MAP_ROWS = 32;

    // Tilemap word fields: [15:12] palette, [11:0] tile code
    localparam int unsigned MAP_PAL_MSB  = 15;
    localparam int unsigned MAP_PAL_LSB  = 12;
    localparam int unsigned MAP_CODE_MSB = 11;
    localparam int unsigned MAP_CODE_LSB = 0;

    // Per-line render sequencer
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MAP  = 3'd1,
        ST_MAPW = 3'd2,
        ST_REQ  = 3'd3,
        ST_DRAW = 3'd4
    } draw_state_e;

endpackage

// File: rtl/jtcop_bac06_lbuf.sv
// Double line buffer for the BAC06 renderer.
// 512x8 memory split in two 256-pixel halves selected by bank. The render
// side writes half 'bank'; the display side reads half '~bank' at
// hdump[7:0] on pxl_cen. bank toggles on every line start.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             line-start pulse (swaps halves)
//   we, waddr, wdata  render write port
//   pxl_cen, hdump    display read side
//   pxl               registered pixel output, BLANK_PXL when hdump[8]=1
module jtcop_bac06_lbuf #(
    parameter logic [7:0] BLANK_PXL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic       pxl_cen,
    input  logic [8:0] hdump,
    output logic [7:0] pxl
);

    logic [7:0] mem [512];
    logic       bank;

    // Bank swap on every line start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= 1'b0;
        end else if (start) begin
            bank <= ~bank;
        end
    end

    // Render-side write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{bank, waddr}] <= wdata;
        end
    end

    // Display-side read, blanked outside the 256 visible pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pxl <= 8'h00;
        end else if (pxl_cen) begin
            pxl <= hdump[8] ? BLANK_PXL : mem[{~bank, hdump[7:0]}];
        end
    end

endmodule

// File: rtl/jtcop_bac06_draw.sv
// Per-line tile renderer for one BAC06 playfield layer.
// On start it walks the tilemap row at (vrender + vscr), fetching TILES
// map words and four 4bpp ROM words per tile, and writes 256 pixels into
// the render half of a double line buffer; the other half is shown.
// Optional feature: define JTCOP_BAC06_FLIP_EN to honour 'flip'
// (mirrored buffer writes, inverted vrender). Otherwise flip is ignored.
// Ports:
//   clk, rst_n, pxl_cen            clock, async reset, pixel enable
//   start, vrender, hscr, vscr     line start and scroll inputs
//   hdump, flip                    display position, screen flip
//   map_addr / map_data            tilemap RAM read (1 clk latency)
//   rom_cs / rom_addr / rom_data / rom_ok   graphics ROM handshake
//   busy                           high while rendering
//   pxl                            {palette, colour} for hdump
module jtcop_bac06_draw
    import jtcop_pkg::*;
#(
    parameter int unsigned TILES     = 17,
    parameter logic [7:0]  BLANK_PXL = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    input  logic        start,
    input  logic [8:0]  vrender,
    input  logic [8:0]  hdump,
    input  logic [9:0]  hscr,
    input  logic [8:0]  vscr,
    input  logic        flip,
    output logic [10:0] map_addr,
    input  logic [15:0] map_data,
    output logic        rom_cs,
    output logic [17:0] rom_addr,
    input  logic [15:0] rom_data,
    input  logic        rom_ok,
    output logic        busy,
    output logic [7:0]  pxl
);

    localparam int unsigned COL_W = $clog2(MAP_COLS);
    localparam int unsigned ROW_W = $clog2(MAP_ROWS);
    localparam int unsigned T_W   = 5;

    draw_state_e      st, st_nxt;
    logic [T_W-1:0]   t, t_nxt;
    logic [1:0]       word, word_nxt;
    logic [1:0]       pcnt, pcnt_nxt;
    logic             req_first, req_first_nxt;
    logic [3:0]       pal, pal_nxt;
    logic [11:0]      code, code_nxt;
    logic [15:0]      pix, pix_nxt;
    logic [ROW_W-1:0] row, row_nxt;
    logic [3:0]       tile_y, tile_y_nxt;
    logic [COL_W-1:0] col0, col0_nxt;
    logic [3:0]       fine, fine_nxt;
    logic [10:0]      map_addr_nxt;
    logic             rom_cs_nxt;
    logic [17:0]      rom_addr_nxt;
    logic             busy_nxt;

    logic [8:0]       vr_c;
    logic [8:0]       y_c;
    logic [T_W-1:0]   t_inc_c;
    logic [9:0]       bx_c;
    logic [3:0]       colour_c;
    logic             we_c;
    logic [7:0]       waddr_c;

`ifdef JTCOP_BAC06_FLIP_EN
    assign vr_c = flip ? ~vrender : vrender;
`else
    logic unused_flip;
    assign unused_flip = flip;
    assign vr_c        = vrender;
`endif

    // Scrolled line position, wraps over the 512-pixel map height
    assign y_c     = vr_c + vscr;
    assign t_inc_c = t + T_W'(1);

    // Buffer position of the current pixel: 16*t + p - fine scroll
    assign bx_c = {1'b0, t, 4'b0000} + {6'b0, word, pcnt} - {6'b0, fine};

    always_comb begin
        colour_c = 4'h0;
        case (pcnt)
            2'd0:    colour_c = pix[15:12];
            2'd1:    colour_c = pix[11:8];
            2'd2:    colour_c = pix[7:4];
            default: colour_c = pix[3:0];
        endcase
    end

    // Only pixels landing in 0..255 are stored (negative or >255 have bit 9/8 set)
    assign we_c = (st == ST_DRAW) && (bx_c[9:8] == 2'b00) && !start;

`ifdef JTCOP_BAC06_FLIP_EN
    assign waddr_c = flip ? ~bx_c[7:0] : bx_c[7:0];
`else
    assign waddr_c = bx_c[7:0];
`endif

    // Next-state and output logic
    always_comb begin
        st_nxt        = st;
        t_nxt         = t;
        word_nxt      = word;
        pcnt_nxt      = pcnt;
        req_first_nxt = req_first;
        pal_nxt       = pal;
        code_nxt      = code;
        pix_nxt       = pix;
        row_nxt       = row;
        tile_y_nxt    = tile_y;
        col0_nxt      = col0;
        fine_nxt      = fine;
        map_addr_nxt  = map_addr;
        rom_cs_nxt    = rom_cs;
        rom_addr_nxt  = rom_addr;

        if (start) begin
            // A start always restarts the line, even mid-render
            st_nxt       = ST_MAP;
            t_nxt        = '0;
            row_nxt      = y_c[8:4];
            tile_y_nxt   = y_c[3:0];
            col0_nxt     = hscr[9:4];
            fine_nxt     = hscr[3:0];
            map_addr_nxt = {y_c[8:4], hscr[9:4]};
            rom_cs_nxt   = 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    st_nxt = ST_IDLE;
                end
                ST_MAP: begin
                    st_nxt = ST_MAPW;
                end
                ST_MAPW: begin
                    pal_nxt       = map_data[MAP_PAL_MSB:MAP_PAL_LSB];
                    code_nxt      = map_data[MAP_CODE_MSB:MAP_CODE_LSB];
                    word_nxt      = 2'd0;
                    rom_cs_nxt    = 1'b1;
                    rom_addr_nxt  = {map_data[MAP_CODE_MSB:MAP_CODE_LSB], tile_y, 2'd0};
                    req_first_nxt = 1'b1;
                    st_nxt        = ST_REQ;
                end
                ST_REQ: begin
                    // rom_ok on the first request cycle belongs to an older access
                    req_first_nxt = 1'b0;
                    if (rom_ok && !req_first) begin
                        pix_nxt    = rom_data;
                        rom_cs_nxt = 1'b0;
                        pcnt_nxt   = 2'd0;
                        st_nxt     = ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    pcnt_nxt = pcnt + 2'd1;
                    if (pcnt == 2'd3) begin
                        if (word != 2'd3) begin
                            word_nxt      = word + 2'd1;
                            rom_cs_nxt    = 1'b1;
                            rom_addr_nxt  = {code, tile_y, word + 2'd1};
                            req_first_nxt = 1'b1;
                            st_nxt        = ST_REQ;
                        end else if (t != T_W'(TILES - 1)) begin
                            t_nxt        = t_inc_c;
                            map_addr_nxt = {row, col0 + {1'b0, t_inc_c}};
                            st_nxt       = ST_MAP;
                        end else begin
                            st_nxt = ST_IDLE;
                        end
                    end
                end
                default: begin
                    st_nxt = ST_IDLE;
                end
            endcase
        end

        busy_nxt = (st_nxt != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            t         <= '0;
            word      <= 2'd0;
            pcnt      <= 2'd0;
            req_first <= 1'b0;
            pal       <= 4'h0;
            code      <= 12'h000;
            pix       <= 16'h0000;
            row       <= '0;
            tile_y    <= 4'h0;
            col0      <= '0;
            fine      <= 4'h0;
            map_addr  <= 11'h000;
            rom_cs    <= 1'b0;
            rom_addr  <= 18'h00000;
            busy      <= 1'b0;
        end else begin
            st        <= st_nxt;
            t         <= t_nxt;
            word      <= word_nxt;
            pcnt      <= pcnt_nxt;
            req_first <= req_first_nxt;
            pal       <= pal_nxt;
            code      <= code_nxt;
            pix       <= pix_nxt;
            row       <= row_nxt;
            tile_y    <= tile_y_nxt;
            col0      <= col0_nxt;
            fine      <= fine_nxt;
            map_addr  <= map_addr_nxt;
            rom_cs    <= rom_cs_nxt;
            rom_addr  <= rom_addr_nxt;
            busy      <= busy_nxt;
        end
    end

    jtcop_bac06_lbuf #(
        .BLANK_PXL (BLANK_PXL)
    ) u_lbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .we      (we_c),
        .waddr   (waddr_c),
        .wdata   ({pal, colour_c}),
        .pxl_cen (pxl_cen),
        .hdump   (hdump),
        .pxl     (pxl)
    );

endmodule

// File: tb/tb_jtcop_bac06_draw.sv
// Testbench for jtcop_bac06_draw: tilemap RAM and ROM models, a line-level
// reference model (buffer pixel bx shows map pixel hscr+bx of line y) and a
// pixel scoreboard fed by the display sweep and drained by a monitor.
module tb_jtcop_bac06_draw;

`ifdef JTCOP_BAC06_FLIP_EN
    localparam bit FLIP_EN = 1'b1;
`else
    localparam bit FLIP_EN = 1'b0;
`endif
    localparam logic [7:0] BLANK = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pxl_cen = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  vrender = '0;
    logic [8:0]  hdump = '0;
    logic [9:0]  hscr = '0;
    logic [8:0]  vscr = '0;
    logic        flip = 1'b0;
    logic [10:0] map_addr;
    logic [15:0] map_data;
    logic        rom_cs;
    logic [17:0] rom_addr;
    logic [15:0] rom_data = '0;
    logic        rom_ok = 1'b0;
    logic        busy;
    logic [7:0]  pxl;

    always #5 clk = ~clk;

    jtcop_bac06_draw dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .start    (start),
        .vrender  (vrender),
        .hdump    (hdump),
        .hscr     (hscr),
        .vscr     (vscr),
        .flip     (flip),
        .map_addr (map_addr),
        .map_data (map_data),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .busy     (busy),
        .pxl      (pxl)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Tilemap RAM: one clk read latency
    logic [15:0] map_mem [2048];
    always @(posedge clk) map_data <= map_mem[map_addr];

    // ROM: hashed contents with a few directed overrides
    logic [15:0] rom_ovr [int];
    function automatic logic [15:0] rom_word(input logic [17:0] a);
        logic [31:0] h;
        if (rom_ovr.exists(int'(a))) return rom_ovr[int'(a)];
        h = {14'd0, a} * 32'h9E3779B1;
        return h[31:16] ^ h[15:0];
    endfunction

    // ROM responder: rom_ok after rom_dly cycles of rom_cs; optional junk rom_ok while idle
    int rom_dly  = 0;
    bit rom_garb = 1'b0;
    int rom_cnt  = 0;
    always @(posedge clk) begin
        if (rom_cs) begin
            if (rom_cnt >= rom_dly) begin
                rom_ok   <= 1'b1;
                rom_data <= rom_word(rom_addr);
            end else begin
                rom_ok   <= 1'b0;
                rom_data <= 16'($urandom);
            end
            rom_cnt <= rom_cnt + 1;
        end else begin
            rom_cnt  <= 0;
            rom_ok   <= rom_garb;
            rom_data <= 16'($urandom);
        end
    end

    // Scoreboard
    logic [7:0] exp_q [$];
    logic [8:0] hq [$];
    logic [7:0] mon_e;
    logic [8:0] mon_h;
    always @(posedge clk) begin
        if (pxl_cen === 1'b1 && rst_n === 1'b1) begin
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pxl_unexpected: got %h expected no sample", pxl);
            end else begin
                mon_e = exp_q.pop_front();
                mon_h = hq.pop_front();
                check($sformatf("pxl h=%0d", mon_h), 32'(pxl), 32'(mon_e));
            end
        end
    end

    // Reference model
    logic [7:0] nxt_line  [256];
    logic [7:0] prev_line [256];
    bit         prev_valid = 1'b0;

    function automatic int line_y(input logic [8:0] vs, input logic [8:0] vr, input logic fl);
        logic [8:0] v;
        v = (FLIP_EN && fl) ? ~vr : vr;
        return (int'(v) + int'(vs)) % 512;
    endfunction

    task automatic model_line(input logic [9:0] hs, input logic [8:0] vs, input logic [8:0] vr, input logic fl);
        int y, xm, col, px, dst, code;
        logic [15:0] m, w;
        logic [17:0] ra;
        y = line_y(vs, vr, fl);
        for (int bx = 0; bx < 256; bx++) begin
            xm   = (int'(hs) + bx) % 1024;
            col  = xm / 16;
            px   = xm % 16;
            m    = map_mem[(y / 16) * 64 + col];
            code = int'(m[11:0]);
            ra   = 18'(code * 64 + (y % 16) * 4 + px / 4);
            w    = rom_word(ra);
            dst  = (FLIP_EN && fl) ? 255 - bx : bx;
            nxt_line[dst] = {m[15:12], 4'(w >> (12 - 4 * (px % 4)))};
        end
    endtask

    task automatic pulse_start(input logic [9:0] hs, input logic [8:0] vs, input logic [8:0] vr, input logic fl);
        @(negedge clk);
        hscr = hs; vscr = vs; vrender = vr; flip = fl; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_t0(input logic [9:0] hs, input logic [8:0] vs, input logic [8:0] vr, input logic fl);
        int y;
        y = line_y(vs, vr, fl);
        check("busy_after_start", 32'(busy), 32'd1);
        check("map_addr_t0", 32'(map_addr), 32'((y / 16) * 64 + int'(hs) / 16));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3072) begin
            @(negedge clk);
            n++;
        end
        check("busy_done", 32'(busy), 32'd0);
    endtask

    task automatic sweep();
        for (int h = 0; h < 260; h++) begin
            @(negedge clk);
            hdump   = 9'(h);
            pxl_cen = 1'b1;
            exp_q.push_back(h < 256 ? prev_line[h] : BLANK);
            hq.push_back(9'(h));
            @(negedge clk);
            pxl_cen = 1'b0;
            repeat (6) @(negedge clk);
        end
    endtask

    // Render one line and display the previous one
    task automatic render(input logic [9:0] hs, input logic [8:0] vs, input logic [8:0] vr, input logic fl, input int dly);
        int n, y, code;
        model_line(hs, vs, vr, fl);
        rom_dly  = dly;
        rom_garb = 1'($urandom);
        pulse_start(hs, vs, vr, fl);
        check_t0(hs, vs, vr, fl);
        y    = line_y(vs, vr, fl);
        code = int'(map_mem[(y / 16) * 64 + int'(hs) / 16][11:0]);
        n = 0;
        while (!rom_cs && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rom_addr_first", 32'(rom_addr), 32'(code * 64 + (y % 16) * 4));
        if (prev_valid) sweep();
        wait_idle();
        prev_line  = nxt_line;
        prev_valid = 1'b1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2048; i++) map_mem[i] = 16'($urandom);
        map_mem[0]  = 16'h1005;
        rom_ovr[320] = 16'h0123;
        rom_ovr[321] = 16'h4567;
        rom_ovr[322] = 16'h89AB;
        rom_ovr[323] = 16'hCDEF;

        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rom_cs", 32'(rom_cs), 32'd0);
        check("rst_map_addr", 32'(map_addr), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_pxl", 32'(pxl), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic fetch
        render(10'd0, 9'd0, 9'd0, 1'b0, 0);
        for (int h = 0; h < 16; h++) prev_line[h] = 8'h10 + 8'(h);
        // Fine scroll
        render(10'd4, 9'd0, 9'd0, 1'b0, 1);
        for (int h = 0; h < 12; h++) prev_line[h] = 8'h14 + 8'(h);
        // ROM stall
        render(10'd0, 9'd0, 9'd0, 1'b0, 20);
        for (int h = 0; h < 16; h++) prev_line[h] = 8'h10 + 8'(h);
        // Vertical wrap: y = 0x010, first map_addr 64
        render(10'd0, 9'h1F0, 9'h020, 1'b0, 2);

        for (int i = 0; i < 6; i++)
            render(10'($urandom), 9'($urandom), 9'($urandom_range(0, 255)), 1'($urandom), $urandom_range(0, 3));

        // Early start: abort line A after 100 cycles, line B then fully rendered
        begin
            logic [9:0] hs;
            logic [8:0] vs, vr;
            pulse_start(10'($urandom), 9'($urandom), 9'($urandom), 1'b0);
            repeat (100) @(negedge clk);
            hs = 10'($urandom); vs = 9'($urandom); vr = 9'($urandom_range(0, 255));
            model_line(hs, vs, vr, 1'b0);
            pulse_start(hs, vs, vr, 1'b0);
            check_t0(hs, vs, vr, 1'b0);
            wait_idle();
            prev_line = nxt_line;
        end
        render(10'($urandom), 9'($urandom), 9'($urandom_range(0, 255)), 1'b0, 1);

        // Mid-line reset while drawing
        pulse_start(10'($urandom), 9'($urandom), 9'($urandom), 1'b0);
        @(negedge clk);
        hdump = 9'd5; pxl_cen = 1'b1;
        exp_q.push_back(prev_line[5]); hq.push_back(9'd5);
        @(negedge clk);
        pxl_cen = 1'b0;
        n = 0;
        while (!rom_cs && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (rom_cs && n < 100) begin @(negedge clk); n++; end
        check("reach_draw", 32'(rom_cs), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rom_cs", 32'(rom_cs), 32'd0);
        check("mid_rst_pxl", 32'(pxl), 32'd0);
        check("mid_rst_map_addr", 32'(map_addr), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_rst", 32'(busy), 32'd0);
        prev_valid = 1'b0;

        render(10'($urandom), 9'($urandom), 9'($urandom_range(0, 255)), 1'($urandom), 0);
        render(10'($urandom), 9'($urandom), 9'($urandom_range(0, 255)), 1'($urandom), 3);

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
